// File: rtl/burst_rd_seq_if.sv
// Handshake bundle between a burst requester, burst_rd_seq and the downstream read FSM.
// The slave modport is the sequencer's view; master is the requester/responder side.
interface burst_rd_seq_if #(
  parameter int unsigned LEN_W = 4
) ();

  logic             start;
  logic [LEN_W-1:0] len;
  logic             ds;
  logic             go;
  logic             busy;
  logic             done;
  logic             err;
  logic [LEN_W-1:0] beat_cnt;

  modport master (
    output start, len, ds,
    input  go, busy, done, err, beat_cnt
  );

  modport slave (
    input  start, len, ds,
    output go, busy, done, err, beat_cnt
  );

endinterface

// File: rtl/burst_rd_seq.sv
// Burst read sequencer: launches one downstream read per beat and counts completions.
// Define BURST_RD_SEQ_TIMEOUT_EN to add the per-beat WAIT timeout, ERR state and sticky err.
module burst_rd_seq #(
  parameter int unsigned LEN_W   = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  burst_rd_seq_if.slave bus_io
);

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StFin, StErr} state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] cnt_inc;

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : gen_bad_timeout
    $error("burst_rd_seq: TIMEOUT must be in 1..255");
  end

`ifdef BURST_RD_SEQ_TIMEOUT_EN
  localparam logic [7:0] TimerMax = 8'(TIMEOUT - 1);
  logic [7:0] timer_q, timer_d;
  logic       err_q, err_d;
`endif

  assign cnt_inc = cnt_q + LEN_W'(1);

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
`ifdef BURST_RD_SEQ_TIMEOUT_EN
    timer_d = timer_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus_io.start) begin
          len_d   = bus_io.len;
          cnt_d   = '0;
`ifdef BURST_RD_SEQ_TIMEOUT_EN
          err_d   = 1'b0;
`endif
          // A zero-length burst completes without launching any beat.
          state_d = (bus_io.len == '0) ? StFin : StIssue;
        end
      end
      StIssue: begin
`ifdef BURST_RD_SEQ_TIMEOUT_EN
        timer_d = '0;
`endif
        state_d = StWait;
      end
      StWait: begin
        // ds takes priority over a timer expiring in the same cycle.
        if (bus_io.ds) begin
          cnt_d   = cnt_inc;
          state_d = (cnt_inc == len_q) ? StFin : StIssue;
        end
`ifdef BURST_RD_SEQ_TIMEOUT_EN
        else if (timer_q == TimerMax) begin
          err_d   = 1'b1;
          state_d = StErr;
        end else begin
          timer_d = timer_q + 8'd1;
        end
`endif
      end
      StFin:   state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      len_q   <= '0;
      cnt_q   <= '0;
`ifdef BURST_RD_SEQ_TIMEOUT_EN
      timer_q <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
`ifdef BURST_RD_SEQ_TIMEOUT_EN
      timer_q <= timer_d;
      err_q   <= err_d;
`endif
    end
  end

  assign bus_io.go       = (state_q == StIssue);
  assign bus_io.done     = (state_q == StFin);
  assign bus_io.busy     = (state_q != StIdle);
  assign bus_io.beat_cnt = cnt_q;
`ifdef BURST_RD_SEQ_TIMEOUT_EN
  assign bus_io.err      = err_q;
`else
  assign bus_io.err      = 1'b0;
`endif

endmodule

// File: tb/tb_burst_rd_seq.sv
// Self-checking bench for burst_rd_seq: scenario tasks plus a done/go monitor that pops
// expected final beat counts from a scoreboard queue.
module tb_burst_rd_seq;

  localparam int unsigned LEN_W = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   go_cnt  = 0;
  int   cyc     = 0;
  int   last_go = -100;
  int   exp_q[$];

  burst_rd_seq_if #(.LEN_W(LEN_W)) bus ();

  burst_rd_seq #(
    .LEN_W   (LEN_W),
    .TIMEOUT (15)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus_io (bus.slave)
  );

  always #5 clk = ~clk;

  // Monitor: go spacing and done-vs-scoreboard checks, sampled on the falling edge.
  always @(negedge clk) begin
    int e;
    cyc++;
    if (rst_n && bus.go) begin
      go_cnt++;
      if (last_go >= 0) begin
        n_tests++;
        if (cyc - last_go < 2) begin
          n_fail++;
          $display("FAIL go_spacing: got %0d cycles, required >= 2", cyc - last_go);
        end
      end
      last_go = cyc;
    end
    if (rst_n && bus.done) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_done: got done with beat_cnt %0d, required no done",
                 bus.beat_cnt);
      end else begin
        e = exp_q.pop_front();
        if (int'(bus.beat_cnt) != e) begin
          n_fail++;
          $display("FAIL done_beat_cnt: got %0d, required %0d", bus.beat_cnt, e);
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_go(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (bus.go) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // Answers nbeats go pulses with a ds strobe dly cycles after each; stops early on no go.
  task automatic serve(input int nbeats, input int dly, output int served);
    bit seen;
    served = 0;
    for (int b = 0; b < nbeats; b++) begin
      wait_go(seen);
      if (!seen) return;
      tick(dly);
      bus.ds = 1'b1;
      tick();
      bus.ds = 1'b0;
      served++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({bus.go, bus.done, bus.busy, bus.err, bus.beat_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b, required all zero",
               {bus.go, bus.done, bus.busy, bus.err, bus.beat_cnt});
    end
    tick(2);
    rst_n = 1'b1;
    tick();
    n_tests++;
    if (bus.busy !== 1'b0 || bus.beat_cnt !== '0) begin
      n_fail++;
      $display("FAIL reset_release: got busy %b cnt %0d, required 0 0", bus.busy, bus.beat_cnt);
    end
  endtask

  task automatic test_basic();
    int g0 = go_cnt;
    bus.start = 1'b1; bus.len = 4'd3;
    exp_q.push_back(3);
    tick();
    bus.start = 1'b0;
    for (int b = 1; b <= 3; b++) begin
      n_tests++;
      if (bus.go !== 1'b1) begin
        n_fail++;
        $display("FAIL basic_go b%0d: got %b, required 1", b, bus.go);
      end
      tick(2);
      bus.ds = 1'b1;
      tick();
      bus.ds = 1'b0;
      n_tests++;
      if (int'(bus.beat_cnt) != b) begin
        n_fail++;
        $display("FAIL basic_beat_cnt: got %0d, required %0d", bus.beat_cnt, b);
      end
    end
    n_tests++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_done: got done %b busy %b, required 1 1", bus.done, bus.busy);
    end
    tick();
    n_tests++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || go_cnt - g0 != 3) begin
      n_fail++;
      $display("FAIL basic_end: got busy %b done %b gos %0d, required 0 0 3",
               bus.busy, bus.done, go_cnt - g0);
    end
  endtask

  task automatic test_zero_len();
    int g0 = go_cnt;
    bus.start = 1'b1; bus.len = 4'd0;
    exp_q.push_back(0);
    tick();
    bus.start = 1'b0;
    n_tests++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b1 || bus.go !== 1'b0 || bus.beat_cnt !== '0) begin
      n_fail++;
      $display("FAIL zero_fin: got done %b busy %b go %b cnt %0d, required 1 1 0 0",
               bus.done, bus.busy, bus.go, bus.beat_cnt);
    end
    tick();
    n_tests++;
    if (bus.busy !== 1'b0 || go_cnt != g0) begin
      n_fail++;
      $display("FAIL zero_end: got busy %b gos %0d, required 0 0", bus.busy, go_cnt - g0);
    end
  endtask

  task automatic test_expiry_ds();
    bus.start = 1'b1; bus.len = 4'd1;
    exp_q.push_back(1);
    tick();
    bus.start = 1'b0;
    tick(15);  // now in the 15th WAIT cycle
    bus.ds = 1'b1;
    tick();
    bus.ds = 1'b0;
    n_tests++;
    if (bus.done !== 1'b1 || bus.err !== 1'b0 || bus.beat_cnt !== 4'd1) begin
      n_fail++;
      $display("FAIL expiry_ds: got done %b err %b cnt %0d, required 1 0 1",
               bus.done, bus.err, bus.beat_cnt);
    end
    tick();
  endtask

  task automatic test_ignored();
    int g0;
    bus.ds = 1'b1;
    tick();
    bus.ds = 1'b0;
    n_tests++;
    if (bus.busy !== 1'b0 || bus.beat_cnt !== 4'd1 || bus.go !== 1'b0) begin
      n_fail++;
      $display("FAIL stray_ds_idle: got busy %b cnt %0d go %b, required 0 1 0",
               bus.busy, bus.beat_cnt, bus.go);
    end
    g0 = go_cnt;
    bus.start = 1'b1; bus.len = 4'd2;
    exp_q.push_back(2);
    tick();
    bus.len = 4'd7;  // start held high with a different len while busy
    bus.ds = 1'b1;   // stray ds during ISSUE
    tick();
    bus.ds = 1'b0;
    n_tests++;
    if (bus.beat_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL stray_ds_issue: got %0d, required 0", bus.beat_cnt);
    end
    tick();
    bus.ds = 1'b1;
    tick();
    bus.ds = 1'b0;
    tick();
    bus.ds = 1'b1;
    tick();
    bus.ds = 1'b0;
    bus.start = 1'b0;
    n_tests++;
    if (bus.done !== 1'b1 || bus.beat_cnt !== 4'd2) begin
      n_fail++;
      $display("FAIL busy_start: got done %b cnt %0d, required 1 2", bus.done, bus.beat_cnt);
    end
    tick();
    n_tests++;
    if (go_cnt - g0 != 2 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_start_gos: got %0d gos busy %b, required 2 0", go_cnt - g0, bus.busy);
    end
  endtask

  task automatic test_max_len();
    int g0 = go_cnt;
    int served;
    bus.start = 1'b1; bus.len = 4'd15;
    exp_q.push_back(15);
    tick();
    bus.start = 1'b0;
    serve(15, 1, served);
    tick();
    n_tests++;
    if (served != 15 || go_cnt - g0 != 15 || bus.beat_cnt !== 4'd15 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL max_len: got served %0d gos %0d cnt %0d busy %b, required 15 15 15 0",
               served, go_cnt - g0, bus.beat_cnt, bus.busy);
    end
  endtask

  task automatic test_reset_mid();
    int served;
    bus.start = 1'b1; bus.len = 4'd5;
    tick();
    bus.start = 1'b0;
    serve(2, 1, served);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({bus.go, bus.done, bus.busy, bus.err, bus.beat_cnt} !== '0 || served != 2) begin
      n_fail++;
      $display("FAIL reset_mid: got %b served %0d, required all zero, 2",
               {bus.go, bus.done, bus.busy, bus.err, bus.beat_cnt}, served);
    end
    tick();
    rst_n = 1'b1;
    bus.start = 1'b1; bus.len = 4'd1;
    exp_q.push_back(1);
    tick();
    bus.start = 1'b0;
    n_tests++;
    if (bus.go !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_first_start: got go %b, required 1", bus.go);
    end
    serve(1, 2, served);
    n_tests++;
    if (bus.done !== 1'b1 || bus.beat_cnt !== 4'd1) begin
      n_fail++;
      $display("FAIL reset_resume: got done %b cnt %0d, required 1 1", bus.done, bus.beat_cnt);
    end
    tick();
  endtask

`ifdef BURST_RD_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    int served;
    bus.start = 1'b1; bus.len = 4'd2;
    tick();
    bus.start = 1'b0;
    tick(15);  // 15th WAIT cycle, timer at expiry
    n_tests++;
    if (bus.err !== 1'b0 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_early: got err %b busy %b, required 0 1", bus.err, bus.busy);
    end
    tick();
    n_tests++;
    if (bus.err !== 1'b1 || bus.done !== 1'b0 || bus.beat_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL timeout_err: got err %b done %b cnt %0d, required 1 0 0",
               bus.err, bus.done, bus.beat_cnt);
    end
    tick();
    n_tests++;
    if (bus.err !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_sticky: got err %b busy %b, required 1 0", bus.err, bus.busy);
    end
    bus.start = 1'b1; bus.len = 4'd1;
    exp_q.push_back(1);
    tick();
    bus.start = 1'b0;
    n_tests++;
    if (bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_clear: got err %b, required 0", bus.err);
    end
    serve(1, 1, served);
    tick();
  endtask
`else
  task automatic test_no_timeout();
    bus.start = 1'b1; bus.len = 4'd1;
    exp_q.push_back(1);
    tick();
    bus.start = 1'b0;
    tick(1000);
    n_tests++;
    if (bus.busy !== 1'b1 || bus.err !== 1'b0 || bus.go !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL hang_wait: got busy %b err %b go %b done %b, required 1 0 0 0",
               bus.busy, bus.err, bus.go, bus.done);
    end
    bus.ds = 1'b1;
    tick();
    bus.ds = 1'b0;
    n_tests++;
    if (bus.done !== 1'b1 || bus.beat_cnt !== 4'd1) begin
      n_fail++;
      $display("FAIL hang_release: got done %b cnt %0d, required 1 1", bus.done, bus.beat_cnt);
    end
    tick();
  endtask
`endif

  initial begin
    bus.start = 1'b0;
    bus.len   = '0;
    bus.ds    = 1'b0;
    test_reset();
    test_basic();
    test_zero_len();
    test_expiry_ds();
    test_ignored();
    test_max_len();
`ifdef BURST_RD_SEQ_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_reset_mid();
    tick(2);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
